// File: rtl/group_quorum_detector_if.sv
// rtl/group_quorum_detector_if.sv - sign-up window control, member inputs and decision outputs
interface group_quorum_detector_if #(
    parameter int NH = 4,
    parameter int NB = 4
);
    localparam int HW = $clog2(NH + 1);
    localparam int BW = $clog2(NB + 1);

    logic          start;
    logic          close;
    logic [NH-1:0] h;
    logic [NB-1:0] b;
    logic [HW-1:0] hcount;
    logic [BW-1:0] bcount;
    logic          busy;
    logic          done;
    logic          p;

    modport master (
        output start, close, h, b,
        input  hcount, bcount, busy, done, p
    );

    modport slave (
        input  start, close, h, b,
        output hcount, bcount, busy, done, p
    );
endinterface

// File: rtl/group_quorum_detector.sv
// rtl/group_quorum_detector.sv - windowed two-group quorum detector with sticky per-member sign-up
module group_quorum_detector #(
    parameter int NH  = 4,
    parameter int NB  = 4,
    parameter int QH  = 1,
    parameter int QB  = 1,
    parameter int WIN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    group_quorum_detector_if.slave bus
);
    localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int HW = $clog2(NH + 1);
    localparam int BW = $clog2(NB + 1);

    typedef enum logic [1:0] {IDLE, OPEN, DONE} state_t;

    state_t        state, state_nxt;
    logic [NH-1:0] hmem, hmem_nxt;
    logic [NB-1:0] bmem, bmem_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          p, p_nxt;

    function automatic logic [HW-1:0] hpop(input logic [NH-1:0] v);
        logic [HW-1:0] n;
        n = '0;
        for (int i = 0; i < NH; i++) n = n + HW'(v[i]);
        return n;
    endfunction

    function automatic logic [BW-1:0] bpop(input logic [NB-1:0] v);
        logic [BW-1:0] n;
        n = '0;
        for (int i = 0; i < NB; i++) n = n + BW'(v[i]);
        return n;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hmem  <= '0;
            bmem  <= '0;
            cnt   <= '0;
            p     <= 1'b0;
        end else begin
            state <= state_nxt;
            hmem  <= hmem_nxt;
            bmem  <= bmem_nxt;
            cnt   <= cnt_nxt;
            p     <= p_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hmem_nxt  = hmem;
        bmem_nxt  = bmem;
        cnt_nxt   = cnt;
        p_nxt     = p;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    hmem_nxt  = '0;
                    bmem_nxt  = '0;
                    cnt_nxt   = '0;
                    p_nxt     = 1'b0;
                    state_nxt = OPEN;
                end
            end
            OPEN: begin
                hmem_nxt = hmem | bus.h;
                bmem_nxt = bmem | bus.b;
                // Decision uses the membership being written on the exit edge.
                if (cnt == CW'(WIN - 1) || bus.close) begin
                    p_nxt     = (int'(hpop(hmem_nxt)) >= QH) && (int'(bpop(bmem_nxt)) >= QB);
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.hcount = hpop(hmem);
    assign bus.bcount = bpop(bmem);
    assign bus.busy   = (state == OPEN);
    assign bus.done   = (state == DONE);
    assign bus.p      = p;
endmodule

// File: tb/tb_group_quorum_detector.sv
// tb/tb_group_quorum_detector.sv - directed vectors and window sequences for group_quorum_detector
module tb_group_quorum_detector;
    logic       clk = 1'b0;
    logic       s_rst = 1'b1;
    logic       s_start = 1'b0;
    logic       s_close = 1'b0;
    logic [3:0] s_h = '0;
    logic [3:0] s_b = '0;
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    group_quorum_detector_if #(.NH(4), .NB(4)) ifa ();
    group_quorum_detector_if #(.NH(4), .NB(4)) ifb ();
    group_quorum_detector_if #(.NH(4), .NB(4)) ifc ();
    group_quorum_detector_if #(.NH(2), .NB(2)) ifd ();

    assign ifa.start = s_start; assign ifa.close = s_close; assign ifa.h = s_h; assign ifa.b = s_b;
    assign ifb.start = s_start; assign ifb.close = s_close; assign ifb.h = s_h; assign ifb.b = s_b;
    assign ifc.start = s_start; assign ifc.close = s_close; assign ifc.h = s_h; assign ifc.b = s_b;

    group_quorum_detector #(.NH(4), .NB(4), .QH(1), .QB(1), .WIN(4))  u_a (.clk(clk), .rst(s_rst), .bus(ifa));
    group_quorum_detector #(.NH(4), .NB(4), .QH(2), .QB(1), .WIN(4))  u_b (.clk(clk), .rst(s_rst), .bus(ifb));
    group_quorum_detector #(.NH(4), .NB(4), .QH(1), .QB(1), .WIN(16)) u_c (.clk(clk), .rst(s_rst), .bus(ifc));
    group_quorum_detector #(.NH(2), .NB(2), .QH(1), .QB(1), .WIN(1))  u_d (.clk(clk), .rst(s_rst), .bus(ifd));

    typedef struct {
        logic [3:0] h;
        logic [3:0] b;
        int         pa;
        int         pb;
        int         hc;
        int         bc;
    } win_vec_t;

    typedef struct {
        logic [1:0] h;
        logic [1:0] b;
        int         p;
    } deg_vec_t;

    win_vec_t wv[4];
    deg_vec_t dv[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        s_rst = 1'b1; s_start = 1'b0; s_close = 1'b0; s_h = '0; s_b = '0;
        step();
        s_rst = 1'b0;
    endtask

    // Full WIN=4 window with h/b held on every OPEN edge; a and b instances share the stimulus.
    task automatic run_win4(input logic [3:0] hv, input logic [3:0] bv,
                            input int pa, input int pb, input int hc, input int bc);
        s_start = 1'b1;
        step();
        chk("win_busy_e0", int'(ifa.busy), 1);
        s_start = 1'b0; s_h = hv; s_b = bv;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k < 4) chk("win_nodone", int'(ifa.done), 0);
        end
        chk("win_done", int'(ifa.done), 1);
        chk("win_busy_low", int'(ifa.busy), 0);
        chk("win_pa", int'(ifa.p), pa);
        chk("win_pb", int'(ifb.p), pb);
        chk("win_hcount", int'(ifa.hcount), hc);
        chk("win_bcount", int'(ifa.bcount), bc);
        s_h = '0; s_b = '0;
        step();
        chk("win_done_once", int'(ifa.done), 0);
        chk("win_p_held", int'(ifa.p), pa);
        chk("win_hcount_held", int'(ifa.hcount), hc);
    endtask

    initial begin
        wv[0] = '{4'b0001, 4'b0000, 0, 0, 1, 0};
        wv[1] = '{4'b0011, 4'b0100, 1, 1, 2, 1};
        wv[2] = '{4'b1111, 4'b1111, 1, 1, 4, 4};
        wv[3] = '{4'b0000, 4'b1000, 0, 0, 0, 1};

        dv[0]  = '{2'b00, 2'b00, 0}; dv[1]  = '{2'b00, 2'b01, 0}; dv[2]  = '{2'b00, 2'b10, 0}; dv[3]  = '{2'b00, 2'b11, 0};
        dv[4]  = '{2'b01, 2'b00, 0}; dv[5]  = '{2'b01, 2'b01, 1}; dv[6]  = '{2'b01, 2'b10, 1}; dv[7]  = '{2'b01, 2'b11, 1};
        dv[8]  = '{2'b10, 2'b00, 0}; dv[9]  = '{2'b10, 2'b01, 1}; dv[10] = '{2'b10, 2'b10, 1}; dv[11] = '{2'b10, 2'b11, 1};
        dv[12] = '{2'b11, 2'b00, 0}; dv[13] = '{2'b11, 2'b01, 1}; dv[14] = '{2'b11, 2'b10, 1}; dv[15] = '{2'b11, 2'b11, 1};

        ifd.start = 1'b0; ifd.close = 1'b0; ifd.h = '0; ifd.b = '0;

        // Reset state
        do_reset();
        chk("rst_p", int'(ifa.p), 0);
        chk("rst_done", int'(ifa.done), 0);
        chk("rst_busy", int'(ifa.busy), 0);
        chk("rst_hcount", int'(ifa.hcount), 0);
        chk("rst_bcount", int'(ifa.bcount), 0);

        // Held-pattern windows
        for (int i = 0; i < 4; i++) run_win4(wv[i].h, wv[i].b, wv[i].pa, wv[i].pb, wv[i].hc, wv[i].bc);

        // Quorum of 2 hikers with a duplicate and a final-cycle basketballer
        do_reset();
        s_start = 1'b1; step(); s_start = 1'b0;
        s_h = 4'b0001; step();
        s_h = 4'b0001; step();
        s_h = 4'b0100; step();
        s_h = 4'b0000; s_b = 4'b1000; step();
        chk("quorum_done", int'(ifb.done), 1);
        chk("quorum_p", int'(ifb.p), 1);
        chk("quorum_hcount", int'(ifb.hcount), 2);
        chk("quorum_bcount", int'(ifb.bcount), 1);
        s_b = '0; step();

        // Early close on the long window
        do_reset();
        s_start = 1'b1; step(); s_start = 1'b0;
        step();
        chk("close_nodone_e1", int'(ifc.done), 0);
        s_close = 1'b1; s_h = 4'b0011; s_b = 4'b0100; step();
        chk("close_done", int'(ifc.done), 1);
        chk("close_busy_low", int'(ifc.busy), 0);
        chk("close_p", int'(ifc.p), 1);
        s_close = 1'b0; s_h = '0; s_b = '0; step();
        chk("close_idle", int'(ifc.done), 0);

        // Start mid-OPEN does not restart the counter; Start in the Done cycle is ignored
        do_reset();
        s_start = 1'b1; step();
        step();
        s_start = 1'b0; step();
        step();
        chk("midstart_nodone_e3", int'(ifa.done), 0);
        step();
        chk("midstart_done_e4", int'(ifa.done), 1);
        s_start = 1'b1; step();
        chk("donestart_busy", int'(ifa.busy), 0);
        chk("donestart_done", int'(ifa.done), 0);
        s_start = 1'b0; step();
        chk("donestart_still_idle", int'(ifa.busy), 0);

        // Close in IDLE is ignored, next window runs full length
        s_close = 1'b1; step(); step();
        chk("idleclose_busy", int'(ifa.busy), 0);
        chk("idleclose_done", int'(ifa.done), 0);
        s_close = 1'b0;
        run_win4(4'b0010, 4'b0001, 1, 0, 1, 1);

        // Mid-window reset aborts without a Done pulse
        do_reset();
        s_start = 1'b1; step(); s_start = 1'b0;
        s_h = 4'b1111; s_b = 4'b1111; step();
        s_rst = 1'b1; step();
        chk("abort_busy", int'(ifa.busy), 0);
        chk("abort_done", int'(ifa.done), 0);
        chk("abort_p", int'(ifa.p), 0);
        chk("abort_hcount", int'(ifa.hcount), 0);
        chk("abort_bcount", int'(ifa.bcount), 0);
        s_rst = 1'b0; s_h = '0; s_b = '0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("abort_no_done", int'(ifa.done), 0);
        end
        run_win4(4'b0000, 4'b0000, 0, 0, 0, 0);

        // Degenerate WIN=1 sweep
        for (int i = 0; i < 16; i++) begin
            ifd.start = 1'b1; ifd.h = dv[i].h; ifd.b = dv[i].b;
            step();
            chk("deg_busy_e0", int'(ifd.busy), 1);
            chk("deg_nodone_e0", int'(ifd.done), 0);
            ifd.start = 1'b0;
            step();
            chk("deg_done", int'(ifd.done), 1);
            chk("deg_p", int'(ifd.p), dv[i].p);
            ifd.h = '0; ifd.b = '0;
            step();
            chk("deg_idle", int'(ifd.done), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/group_quorum_detector.md
# group_quorum_detector

Clocked, parametrised quorum detector for group-outing decisions. Over a sign-up window, it collects one-hot sign-up pulses from NH hikers and NB basketballers. Each member is counted once. When the window closes, it asserts P if both groups met their quorum. It sits where the combinational two-group "party" check sits today. With NH=NB=2, QH=QB=1 and a one-cycle window it reduces to P = (H1|H2)&(B1|B2).

## Interface
- NH, 4: number of hiker inputs (≥1)
- NB, 4: number of basketballer inputs (≥1)
- QH, 1: hiker quorum (0..NH)
- QB, 1: basketballer quorum (0..NB)
- WIN, 16: maximum window length in OPEN cycles (≥1)
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset, synchronous, active-high
- Start  in  1  open a new sign-up window (honoured only in IDLE)
- Close  in  1  close the window early (honoured only in OPEN)
- H  in  NH  hiker sign-up bits, sampled each OPEN cycle
- B  in  NB  basketballer sign-up bits, sampled each OPEN cycle
- HCount  out  clog2(NH+1)  number of distinct hikers signed up
- BCount  out  clog2(NB+1)  number of distinct basketballers signed up
- Busy  out  1  high while in OPEN
- Done  out  1  one-cycle pulse; the decision is available
- P  out  1  decision: both quorums met; held until next Start

## Operation
- States:
  - IDLE: waiting for Start.
  - OPEN: collecting sign-ups.
  - DONE: one-cycle decision report.
- Registers:
  - HMem[NH], BMem[NB]: sticky membership bits.
  - cnt: OPEN cycle counter, width clog2(WIN).
  - P.
- IDLE:
  - Start=1 → clear HMem, BMem and cnt; clear P; go to OPEN.
  - Otherwise, hold all registers.
- OPEN, every edge:
  - HMem |= H and BMem |= B. Repeated pulses from the same member never double-count.
- OPEN exit: if cnt == WIN-1 or Close=1, go to DONE.
  - Otherwise cnt++.
  - The exit edge's inputs are included in the decision.
- DONE entry edge: P ← (popcount(HMem|H) ≥ QH) && (popcount(BMem|B) ≥ QB). The popcount uses the membership value being written on that edge.
- DONE: lasts exactly one cycle, then IDLE unconditionally. Start in DONE is ignored.
- Start during OPEN is ignored. Close outside OPEN is ignored.
- HCount and BCount are combinational popcounts of the registered HMem and BMem. They are valid in all states and hold their values after DONE until the next Start.
- A quorum of 0 is always met for that group.
- Rst (any state, including mid-window):
  - State goes to IDLE; HMem, BMem and cnt go to 0.
  - P=0, Done=0, Busy=0.
  - No Done pulse is generated for an aborted window.

## Timing
- Reset values: P=0, Done=0, Busy=0, HCount=0, BCount=0.
- Start sampled at edge E0:
  - Busy=1 from E0 until the exit edge.
  - H/B are sampled at edges E1..En.
- Full window: n = WIN.
  - The exit edge is E_WIN.
  - Done=1 and P valid in cycle E_WIN→E_WIN+1.
  - Start-to-decision latency is WIN+1 edges.
- Early close: Close=1 at edge Ek (1 ≤ k ≤ WIN) makes Ek the exit edge. Done follows in the next cycle.
- Done is high for exactly one cycle. Busy and Done are never high together.
- A new Start is accepted at the earliest on the edge after the Done cycle, i.e. with the FSM back in IDLE.

## Test plan
- Reset with NH=NB=4, QH=QB=1, WIN=4: all outputs 0.
  - Start with H=0001 held, B=0 for 4 cycles → Done pulse after 5 edges, P=0, HCount=1, BCount=0.
- Quorum met: QH=2, QB=1.
  - Pulse H[0], H[0] again, then H[2]; pulse B[3] on the final window cycle.
  - Result: P=1, HCount=2 (duplicates not counted), BCount=1. The final-cycle input must be included.
- Early close: WIN=16. At the 2nd OPEN edge, drive Close=1 with H=0011, B=0100.
  - Result: Done 3 edges after Start, P=1 (QH=QB=1), Busy low in the Done cycle.
- Ignored controls:
  - Start asserted mid-OPEN → cnt is not restarted and Done timing is unchanged.
  - Close in IDLE → no effect.
  - Start in the Done cycle → FSM returns to IDLE; no new window opens.
- Mid-window reset: Start, sign up H=1111 and B=1111, then Rst at the 2nd OPEN edge.
  - Result: no Done pulse, P=0, counts=0, Busy=0.
  - A following Start runs a clean window.
- Degenerate config NH=NB=2, QH=QB=1, WIN=1: exhaustively sweep all 16 H/B combinations, one window each.
  - Expect P = (H[0]|H[1]) & (B[0]|B[1]), Done 2 edges after each Start.
